// File: rtl/adder_pipe_lut_pkg.sv
// rtl/adder_pipe_lut_pkg.sv - shared constants, LUT field layout and stage state type for adder_pipe_lut
package adder_pipe_lut_pkg;

    // Default number of operand bits resolved by one LUT slice
    localparam int SLICE_DEFAULT = 2;

    // Bit position of the sum field inside a LUT output word
    localparam int LUT_SUM_LSB = 0;

    // Occupancy of one pipeline stage
    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_FULL  = 1'b1
    } stage_state_t;

    // LUT address is {a_slice, b_slice, cin}
    function automatic int lut_addr_w(input int slice);
        return 2 * slice + 1;
    endfunction

    // LUT output is {carry, sum_slice}
    function automatic int lut_out_w(input int slice);
        return slice + 1;
    endfunction

    // Carry sits directly above the sum field
    function automatic int lut_carry_pos(input int slice);
        return slice;
    endfunction

    // Top bit of the sum field
    function automatic int lut_sum_msb(input int slice);
        return LUT_SUM_LSB + slice - 1;
    endfunction

endpackage

// File: rtl/adder_pipe_lut_slice_add_lut.sv
// rtl/adder_pipe_lut_slice_add_lut.sv - combinational table lookup adding one SLICE-bit slice with carry
module slice_add_lut
    import adder_pipe_lut_pkg::*;
#(
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             carry
);

    localparam int ADDR_W    = lut_addr_w(SLICE);
    localparam int OUT_W     = lut_out_w(SLICE);
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int CARRY_POS = lut_carry_pos(SLICE);
    localparam int SUM_MSB   = lut_sum_msb(SLICE);

    // Table contents: each address decodes to its own slice operands and carry in
    function automatic logic [OUT_W-1:0] lut_entry(input logic [ADDR_W-1:0] addr);
        logic [OUT_W-1:0] ea;
        logic [OUT_W-1:0] eb;
        logic [OUT_W-1:0] ec;
        ea = OUT_W'(addr[ADDR_W-1 -: SLICE]);
        eb = OUT_W'(addr[SLICE -: SLICE]);
        ec = OUT_W'(addr[0]);
        return ea + eb + ec;
    endfunction

    logic [OUT_W-1:0]  lut_rom [DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  entry;

    // Constant ROM; synthesis folds it into a fixed lookup network
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign lut_rom[i] = lut_entry(ADDR_W'(i));
    end

    assign addr  = {a, b, cin};
    assign entry = lut_rom[addr];
    assign sum   = entry[SUM_MSB:LUT_SUM_LSB];
    assign carry = entry[CARRY_POS];

endmodule

// File: rtl/adder_pipe_lut.sv
// rtl/adder_pipe_lut.sv - slice-pipelined LUT adder with valid/ready flow control; ADDER_PIPE_LUT_OVF_EN adds the ovf output
module adder_pipe_lut
    import adder_pipe_lut_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready
`ifdef ADDER_PIPE_LUT_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = (SLICE < 1) ? 1 : WIDTH / SLICE;

    // Reject slicings that cannot tile the operand width
    if (SLICE < 1) begin : g_bad_slice
        $error("adder_pipe_lut: SLICE must be at least 1");
    end else if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("adder_pipe_lut: WIDTH must be a multiple of SLICE");
    end

    // Whole pipeline moves together; a blocked output freezes every stage
    logic advance;

    // Per-stage occupancy
    stage_state_t state_q     [NSLICE];
    stage_state_t state_d     [NSLICE];
    logic         stage_valid [NSLICE];

    // Per-stage data: operands ride along so upper slices reach their stage,
    // finished lower sum slices accumulate in s_q
    logic [WIDTH-1:0] a_q [NSLICE];
    logic [WIDTH-1:0] b_q [NSLICE];
    logic [WIDTH-1:0] s_q [NSLICE];
    logic             c_q [NSLICE];

    // What each stage would load on advance
    logic             up_full [NSLICE];
    logic [WIDTH-1:0] up_a    [NSLICE];
    logic [WIDTH-1:0] up_b    [NSLICE];
    logic [WIDTH-1:0] up_s    [NSLICE];
    logic             up_c    [NSLICE];
    logic [WIDTH-1:0] s_d     [NSLICE];

    logic [SLICE-1:0] slice_sum   [NSLICE];
    logic             slice_carry [NSLICE];

    assign in_ready = !(out_valid && !out_ready);
    assign advance  = in_ready;

    for (genvar k = 0; k < NSLICE; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign up_full[k] = in_valid;
            assign up_a[k]    = a;
            assign up_b[k]    = b;
            assign up_s[k]    = '0;
            assign up_c[k]    = cin;
        end else begin : g_body
            assign up_full[k] = stage_valid[k-1];
            assign up_a[k]    = a_q[k-1];
            assign up_b[k]    = b_q[k-1];
            assign up_s[k]    = s_q[k-1];
            assign up_c[k]    = c_q[k-1];
        end

        slice_add_lut #(
            .SLICE (SLICE)
        ) u_slice (
            .a     (up_a[k][k*SLICE +: SLICE]),
            .b     (up_b[k][k*SLICE +: SLICE]),
            .cin   (up_c[k]),
            .sum   (slice_sum[k]),
            .carry (slice_carry[k])
        );
    end

    // Insert each stage's freshly computed slice into the partial sum it inherits
    always_comb begin
        for (int k = 0; k < NSLICE; k++) begin
            s_d[k] = up_s[k];
            s_d[k][k*SLICE +: SLICE] = slice_sum[k];
        end
    end

    // Stage occupancy register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSLICE; k++) begin
                state_q[k] <= STAGE_EMPTY;
            end
        end else begin
            for (int k = 0; k < NSLICE; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    // Occupancy next state: on advance each stage takes its upstream's occupancy
    always_comb begin
        for (int k = 0; k < NSLICE; k++) begin
            state_d[k] = state_q[k];
            if (advance) begin
                state_d[k] = up_full[k] ? STAGE_FULL : STAGE_EMPTY;
            end
        end
    end

    // Occupancy decode
    always_comb begin
        for (int k = 0; k < NSLICE; k++) begin
            stage_valid[k] = (state_q[k] == STAGE_FULL);
        end
    end

    // Stage data registers; bubbles move data too, their valid bit keeps them harmless
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NSLICE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < NSLICE; k++) begin
                a_q[k] <= up_a[k];
                b_q[k] <= up_b[k];
                s_q[k] <= s_d[k];
                c_q[k] <= slice_carry[k];
            end
        end
    end

    assign s         = s_q[NSLICE-1];
    assign cout      = c_q[NSLICE-1];
    assign out_valid = stage_valid[NSLICE-1];

`ifdef ADDER_PIPE_LUT_OVF_EN
    // Signed overflow: like-signed operands giving an opposite-signed sum
    assign ovf = (a_q[NSLICE-1][WIDTH-1] == b_q[NSLICE-1][WIDTH-1]) &&
                 (s_q[NSLICE-1][WIDTH-1] != a_q[NSLICE-1][WIDTH-1]);
`endif

endmodule

// File: tb/tb_adder_pipe_lut.sv
// tb/tb_adder_pipe_lut.sv - scoreboard testbench for adder_pipe_lut
module tb_adder_pipe_lut;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s;
    logic       cout;
    logic       out_valid;
    logic       out_ready;
    logic       dut_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_acc   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         acc_cyc_q[$];
    int         obs_cyc_q[$];

    adder_pipe_lut #(
        .WIDTH (8),
        .SLICE (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ADDER_PIPE_LUT_OVF_EN
        ,
        .ovf       (dut_ovf)
`endif
    );

`ifndef ADDER_PIPE_LUT_OVF_EN
    assign dut_ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: unsigned sum for {cout,s}, signed range check for ovf
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        int         us;
        int         ss;
        logic [8:0] sum;
        logic       v;
        us  = int'(x) + int'(y) + int'(c);
        ss  = int'($signed(x)) + int'($signed(y)) + int'(c);
        sum = us[8:0];
`ifdef ADDER_PIPE_LUT_OVF_EN
        v = (ss > 127) || (ss < -128);
`else
        v = 1'b0;
`endif
        return {v, sum};
    endfunction

    // One clock: record accepted inputs and delivered outputs, end #1 after the edge
    task automatic cycle();
        @(negedge clk);
        if (!reset && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin));
            acc_cyc_q.push_back(cyc);
            n_acc++;
        end
        if (!reset && out_valid && out_ready) begin
            obs_q.push_back({dut_ovf, cout, s});
            obs_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h expected 00", s); end
        n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
        n_tests++; if (dut_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", dut_ovf); end
        reset = 1'b0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        logic [9:0] got;
        int         gc;
        int         ec;
        clear_q();
        a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) cycle();
        n_tests++;
        if (obs_q.size() == 0 || acc_cyc_q.size() == 0) begin
            n_fail++;
            $display("FAIL single_result: got %0d results %0d accepts, expected 1 each", obs_q.size(), acc_cyc_q.size());
        end else begin
            got = obs_q.pop_front();
            gc  = obs_cyc_q.pop_front();
            ec  = acc_cyc_q.pop_front();
            void'(exp_q.pop_front());
            n_tests++; if (got[8:0] !== 9'h100) begin n_fail++; $display("FAIL single_sum: got %h expected 100", got[8:0]); end
            n_tests++; if (gc - ec !== 4) begin n_fail++; $display("FAIL single_latency: got %0d expected 4", gc - ec); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [4] = '{8'h12, 8'h80, 8'h0F, 8'h00};
        logic [7:0] tb [4] = '{8'h34, 8'h80, 8'hF0, 8'h00};
        logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [8:0] te [4] = '{9'h046, 9'h100, 9'h100, 9'h000};
        logic [9:0] got;
        int         gc;
        int         ec;
        int         first;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && obs_q.size() < 4; i++) cycle();
        n_tests++;
        if (obs_q.size() != 4 || acc_cyc_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results %0d accepts, expected 4 each", obs_q.size(), acc_cyc_q.size());
        end else begin
            first = obs_cyc_q[0];
            for (int i = 0; i < 4; i++) begin
                got = obs_q.pop_front();
                gc  = obs_cyc_q.pop_front();
                ec  = acc_cyc_q.pop_front();
                void'(exp_q.pop_front());
                n_tests++; if (got[8:0] !== te[i]) begin n_fail++; $display("FAIL b2b_sum%0d: got %h expected %h", i, got[8:0], te[i]); end
                n_tests++; if (gc !== first + i) begin n_fail++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, gc, first + i); end
                n_tests++; if (gc - ec !== 4) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d expected 4", i, gc - ec); end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] ta [6] = '{8'h01, 8'h22, 8'hC3, 8'h7F, 8'hAA, 8'h5E};
        logic [7:0] tb [6] = '{8'h02, 8'h33, 8'h4D, 8'h81, 8'h55, 8'h19};
        logic       tc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0] held_exp;
        logic [9:0] got;
        logic [9:0] want;
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; in_valid = 1'b1;
            cycle();
        end
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_full_valid: got %b expected 1", out_valid); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full_ready: got %b expected 0", in_ready); end
        held_exp = (exp_q.size() > 0) ? exp_q[0] : 10'h3FF;
        a = ta[4]; b = tb[4]; cin = tc[4]; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready%0d: got %b expected 0", i, in_ready); end
            n_tests++; if ({cout, s} !== held_exp[8:0]) begin n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, {cout, s}, held_exp[8:0]); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid%0d: got %b expected 1", i, out_valid); end
        end
        n_tests++; if (exp_q.size() != 4) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 4", exp_q.size()); end
        out_ready = 1'b1;
        for (int i = 4; i < 6; i++) begin
            a = ta[i]; b = tb[i]; cin = tc[i]; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && obs_q.size() < 6; i++) cycle();
        n_tests++;
        if (obs_q.size() != 6) begin
            n_fail++;
            $display("FAIL stall_count: got %0d expected 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                got  = obs_q.pop_front();
                want = model(ta[i], tb[i], tc[i]);
                n_tests++; if (got !== want) begin n_fail++; $display("FAIL stall_order%0d: got %h expected %h", i, got, want); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 8'h10 + 8'(i); b = 8'hE5; cin = 1'b1; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
        reset = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
        n_tests++; if ({cout, s} !== 9'h000) begin n_fail++; $display("FAIL midrst_sum: got %h expected 000", {cout, s}); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        clear_q();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) cycle();
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_leak: got %0d results expected 0", obs_q.size()); end
    endtask

`ifdef ADDER_PIPE_LUT_OVF_EN
    task automatic test_ovf();
        logic [7:0] ta [3] = '{8'h7F, 8'h80, 8'h7F};
        logic [7:0] tb [3] = '{8'h01, 8'h80, 8'h80};
        logic [9:0] te [3] = '{10'h280, 10'h300, 10'h0FF};
        logic [9:0] got;
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = ta[i]; b = tb[i]; cin = 1'b0; in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && obs_q.size() < 3; i++) cycle();
        n_tests++;
        if (obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected 3", obs_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = obs_q.pop_front();
                n_tests++; if (got !== te[i]) begin n_fail++; $display("FAIL ovf_case%0d: got %h expected %h", i, got, te[i]); end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [9:0] got;
        logic [9:0] want;
        int         checked;
        int         base;
        clear_q();
        checked = 0;
        base    = n_acc;
        for (int i = 0; i < 60000 && checked < 10000; i++) begin
            if (n_acc - base < 10000) begin
                in_valid = ($urandom_range(3) != 0);
                a        = 8'($urandom);
                b        = 8'($urandom);
                cin      = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(3) != 0);
            cycle();
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                void'(obs_cyc_q.pop_front());
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got %h expected no result", got);
                end else begin
                    want = exp_q.pop_front();
                    void'(acc_cyc_q.pop_front());
                    if (got !== want) begin n_fail++; $display("FAIL rand_op%0d: got %h expected %h", checked, got, want); end
                end
                checked++;
            end
        end
        n_tests++; if (checked != 10000) begin n_fail++; $display("FAIL rand_total: got %0d results expected 10000", checked); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_pending: got %0d outstanding expected 0", exp_q.size()); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef ADDER_PIPE_LUT_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
